// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, rotate helper and parameter legality checks for the arbiter PUF engine
//
// Contents:
//   puf_state_t  controller states
//   rotl         rotate-left of the low `width` bits of a word (upper bits return zero)
//   votes_ok     VOTES must be odd and within 1..15
//   settle_ok    SETTLE_CYC must be at least 1
package puf_pkg;

    // Widest challenge the rotate helper handles; callers zero-extend into it.
    localparam int ROT_MAX_W = 256;

    typedef enum logic [2:0] {
        PUF_IDLE,
        PUF_PRECHARGE,
        PUF_LAUNCH,
        PUF_SAMPLE,
        PUF_DONE
    } puf_state_t;

    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] word,
                                                   input int amount,
                                                   input int width);
        logic [ROT_MAX_W-1:0] mask;
        mask = ~({ROT_MAX_W{1'b1}} << width);
        // Bits pushed above `width` are masked off; the wrapped bits come back in from the right.
        return ((word << amount) | (word >> (width - amount))) & mask;
    endfunction

    function automatic bit votes_ok(input int v);
        return (v >= 1) && (v <= 15) && ((v % 2) == 1);
    endfunction

    function automatic bit settle_ok(input int s);
        return s >= 1;
    endfunction

endpackage

// File: rtl/arbiter_puf_engine_if.sv
// rtl/arbiter_puf_engine_if.sv - request/response handshake bundle of the arbiter PUF engine
//
// Signals:
//   start, challenge      request and its challenge word (requester -> engine)
//   busy                  engine is working on a request
//   resp_valid/resp_ready response handshake
//   response, unstable    majority-voted response and per-bit instability mask
interface arbiter_puf_engine_if #(
    parameter int STAGES = 64,
    parameter int RESP_W = 32
) ();
    logic              start;
    logic [STAGES-1:0] challenge;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [RESP_W-1:0] response;
    logic [RESP_W-1:0] unstable;

    modport master (
        output start, challenge, resp_ready,
        input  busy, resp_valid, response, unstable
    );

    modport slave (
        input  start, challenge, resp_ready,
        output busy, resp_valid, response, unstable
    );
endinterface

// File: rtl/puf_delay_chain.sv
// rtl/puf_delay_chain.sv - crossed-MUX arbiter delay chain with clearable arbiter latch
//
// Ports:
//   launch     rising edge driven into both chain inputs
//   challenge  bit k selects straight (0) or crossed (1) routing at stage k
//   arb_clr    holds the arbiter latch at 0
//   arb_out    1 when the top path arrived first, 0 when the bottom path did
(* dont_touch = "true" *)
module puf_delay_chain #(
    parameter int STAGES = 64
) (
    input  logic              launch,
    input  logic [STAGES-1:0] challenge,
    input  logic              arb_clr,
    output logic              arb_out
);
    logic [STAGES:0] top_path;
    logic [STAGES:0] bot_path;
    logic            arb_q;

    assign top_path[0] = launch;
    assign bot_path[0] = launch;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign top_path[k+1] = challenge[k] ? bot_path[k] : top_path[k];
        assign bot_path[k+1] = challenge[k] ? top_path[k] : bot_path[k];
    end

    // Latch captures whichever path rises first; once both are high neither
    // input differs, so the first decision is held until the next clear.
    always_latch begin
        if (arb_clr) begin
            arb_q <= 1'b0;
        end else if (top_path[STAGES] ^ bot_path[STAGES]) begin
            arb_q <= top_path[STAGES];
        end
    end

    assign arb_out = arb_q;
endmodule

// File: rtl/arbiter_puf_engine.sv
// rtl/arbiter_puf_engine.sv - arbiter PUF controller: precharge/launch/sample sequencing and majority voting
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of arbiter_puf_engine_if (start/challenge in,
//             busy/resp_valid/response/unstable out, resp_ready in)
module arbiter_puf_engine
    import puf_pkg::*;
#(
    parameter int STAGES     = 64,
    parameter int RESP_W     = 32,
    parameter int VOTES      = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    arbiter_puf_engine_if.slave  bus
);
    localparam int CNT_W = $clog2(VOTES + 1);
    localparam int BI_W  = $clog2(RESP_W + 1);
    localparam int PH_W  = $clog2(SETTLE_CYC + 1);
    localparam int ROT_W = $clog2(STAGES);

    if (!votes_ok(VOTES)) begin : g_bad_votes
        $error("VOTES must be odd and within 1..15");
    end
    if (!settle_ok(SETTLE_CYC)) begin : g_bad_settle
        $error("SETTLE_CYC must be at least 1");
    end
    if (STAGES < 2 || STAGES > ROT_MAX_W) begin : g_bad_stages
        $error("STAGES out of supported range");
    end

    puf_state_t        state, next_state;
    logic [STAGES-1:0] chal_q;
    logic [STAGES-1:0] chain_chal;
    logic [ROT_W-1:0]  rot_amt;
    logic [BI_W-1:0]   bit_idx;
    logic [CNT_W-1:0]  vote_cnt, ones_cnt, ones_next;
    logic [PH_W-1:0]   phase_cnt;
    logic [RESP_W-1:0] response_q, unstable_q;
    logic              busy_q, valid_q;
    logic              launch, arb_clr, arb_out;
    logic              phase_end, last_vote, last_bit, handshake;

    assign phase_end = (phase_cnt == PH_W'(SETTLE_CYC - 1));
    assign last_vote = (vote_cnt == CNT_W'(VOTES - 1));
    assign last_bit  = (bit_idx == BI_W'(RESP_W - 1));
    assign handshake = valid_q && bus.resp_ready;
    assign ones_next = ones_cnt + CNT_W'(arb_out);

    // rot_amt tracks bit_idx mod STAGES, so the chain challenge only moves on commit.
    assign chain_chal = STAGES'(rotl(ROT_MAX_W'(chal_q), int'(rot_amt), STAGES));

    puf_delay_chain #(.STAGES(STAGES)) u_chain (
        .launch    (launch),
        .challenge (chain_chal),
        .arb_clr   (arb_clr),
        .arb_out   (arb_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= PUF_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            PUF_IDLE:      if (bus.start) next_state = PUF_PRECHARGE;
            PUF_PRECHARGE: if (phase_end) next_state = PUF_LAUNCH;
            PUF_LAUNCH:    if (phase_end) next_state = PUF_SAMPLE;
            PUF_SAMPLE:    next_state = (last_vote && last_bit) ? PUF_DONE : PUF_PRECHARGE;
            PUF_DONE:      if (handshake) next_state = PUF_IDLE;
            default:       next_state = PUF_IDLE;
        endcase
    end

    // Launch stays high through SAMPLE and the latch is released only then,
    // so the arbiter decision is still held when it is sampled.
    always_comb begin
        launch  = 1'b0;
        arb_clr = 1'b1;
        if (state == PUF_LAUNCH || state == PUF_SAMPLE) begin
            launch  = 1'b1;
            arb_clr = 1'b0;
        end
    end

    // busy/resp_valid are registered one cycle behind the state so busy rises
    // the edge after acceptance; both drop on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            busy_q  <= (state != PUF_IDLE) && !handshake;
            valid_q <= (state == PUF_DONE) && !handshake;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chal_q     <= '0;
            rot_amt    <= '0;
            bit_idx    <= '0;
            vote_cnt   <= '0;
            ones_cnt   <= '0;
            phase_cnt  <= '0;
            response_q <= '0;
            unstable_q <= '0;
        end else begin
            case (state)
                PUF_IDLE: begin
                    if (bus.start) begin
                        chal_q     <= bus.challenge;
                        rot_amt    <= '0;
                        bit_idx    <= '0;
                        vote_cnt   <= '0;
                        ones_cnt   <= '0;
                        phase_cnt  <= '0;
                        response_q <= '0;
                        unstable_q <= '0;
                    end
                end
                PUF_PRECHARGE, PUF_LAUNCH: begin
                    phase_cnt <= phase_end ? '0 : phase_cnt + PH_W'(1);
                end
                PUF_SAMPLE: begin
                    if (!last_vote) begin
                        ones_cnt <= ones_next;
                        vote_cnt <= vote_cnt + CNT_W'(1);
                    end else begin
                        for (int i = 0; i < RESP_W; i++) begin
                            if (bit_idx == BI_W'(i)) begin
                                response_q[i] <= (ones_next > CNT_W'(VOTES / 2));
                                unstable_q[i] <= (ones_next != '0) && (ones_next != CNT_W'(VOTES));
                            end
                        end
                        vote_cnt <= '0;
                        ones_cnt <= '0;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + BI_W'(1);
                            rot_amt <= (rot_amt == ROT_W'(STAGES - 1)) ? '0 : rot_amt + ROT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.resp_valid = valid_q;
    assign bus.response   = response_q;
    assign bus.unstable   = unstable_q;
endmodule

// File: tb/tb_arbiter_puf_engine.sv
// tb/tb_arbiter_puf_engine.sv - directed self-checking bench for arbiter_puf_engine
module tb_arbiter_puf_engine;
    localparam int S   = 8;
    localparam int R   = 4;
    localparam int V   = 3;
    localparam int SC  = 2;
    localparam int R2  = 10;
    localparam int LAT = 1 + R * V * (2 * SC + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbiter_puf_engine_if #(.STAGES(S), .RESP_W(R))  if1 ();
    arbiter_puf_engine_if #(.STAGES(S), .RESP_W(R2)) if2 ();

    arbiter_puf_engine #(.STAGES(S), .RESP_W(R), .VOTES(V), .SETTLE_CYC(SC)) dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    arbiter_puf_engine #(.STAGES(S), .RESP_W(R2), .VOTES(V), .SETTLE_CYC(SC)) dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] cur_votes = '0;

    typedef struct {
        logic [7:0]  chal;
        logic [11:0] votes;      // bit (b*3+v) = vote v of response bit b
        logic [3:0]  exp_resp;
        logic [3:0]  exp_unst;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] c, input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[(i + n) % 8] = c[i];
        return r;
    endfunction

    // Behavioural arbiter for dut1: scripted result per (bit, vote).
    always @(negedge clk) begin
        int idx;
        idx = int'(dut1.bit_idx) * V + int'(dut1.vote_cnt);
        if (idx < 12 && cur_votes[idx]) force dut1.arb_out = 1'b1;
        else                            force dut1.arb_out = 1'b0;
    end

    task automatic run_req(input logic [7:0] chal, input logic [11:0] votes,
                           output int lat, output bit chain_ok);
        cur_votes = votes;
        @(negedge clk);
        if1.challenge = chal;
        if1.start     = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        lat = 0;
        chain_ok = 1'b1;
        while (lat < 300) begin
            @(posedge clk);
            #1 lat++;
            if (if1.resp_valid) break;
            if (dut1.bit_idx < R && dut1.chain_chal !== rotl8(chal, int'(dut1.bit_idx)))
                chain_ok = 1'b0;
        end
    endtask

    task automatic handshake1();
        @(negedge clk) if1.resp_ready = 1'b1;
        @(posedge clk);
        #1 if1.resp_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  ok;
        int  n;

        vecs[0] = '{chal: 8'hA5, votes: 12'hFFF, exp_resp: 4'hF, exp_unst: 4'h0};
        vecs[1] = '{chal: 8'h01, votes: 12'hE83, exp_resp: 4'h9, exp_unst: 4'h5};
        vecs[2] = '{chal: 8'h3C, votes: 12'h000, exp_resp: 4'h0, exp_unst: 4'h0};
        vecs[3] = '{chal: 8'hC3, votes: 12'h3AC, exp_resp: 4'h6, exp_unst: 4'hF};

        if1.start = 1'b0; if1.challenge = '0; if1.resp_ready = 1'b0;
        if2.start = 1'b0; if2.challenge = '0; if2.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",     32'(if1.busy), 32'h0);
        check("reset_valid",    32'(if1.resp_valid), 32'h0);
        check("reset_response", 32'(if1.response), 32'h0);
        check("reset_unstable", 32'(if1.unstable), 32'h0);
        check("reset_launch",   32'(dut1.launch), 32'h0);
        check("reset_arb_clr",  32'(dut1.arb_clr), 32'h1);
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_req(vecs[v].chal, vecs[v].votes, lat, ok);
            check($sformatf("v%0d_latency", v),  32'(lat), 32'(LAT));
            check($sformatf("v%0d_response", v), 32'(if1.response), 32'(vecs[v].exp_resp));
            check($sformatf("v%0d_unstable", v), 32'(if1.unstable), 32'(vecs[v].exp_unst));
            check($sformatf("v%0d_chain", v),    32'(ok), 32'h1);
            check($sformatf("v%0d_busy", v),     32'(if1.busy), 32'h1);
            handshake1();
            check($sformatf("v%0d_valid_drop", v), 32'(if1.resp_valid), 32'h0);
            check($sformatf("v%0d_busy_drop", v),  32'(if1.busy), 32'h0);
            check($sformatf("v%0d_resp_kept", v),  32'(if1.response), 32'(vecs[v].exp_resp));
        end

        // DONE held with resp_ready low while start pulses arrive.
        run_req(8'h01, 12'hE83, lat, ok);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if1.start = (i % 2 == 0);
            if1.challenge = 8'hFF;
            @(posedge clk);
            #1;
            if (if1.resp_valid !== 1'b1 || if1.response !== 4'h9 ||
                if1.unstable !== 4'h5 || if1.busy !== 1'b1) ok = 1'b0;
        end
        if1.start = 1'b0;
        check("hold_stable", 32'(ok), 32'h1);
        check("hold_chal_q", 32'(dut1.chal_q), 32'h01);
        handshake1();
        check("hold_valid_drop", 32'(if1.resp_valid), 32'h0);
        @(posedge clk);
        #1 check("hold_no_restart", 32'(if1.busy), 32'h0);

        // Reset during LAUNCH of bit 2.
        cur_votes = 12'hFFF;
        @(negedge clk);
        if1.challenge = 8'h5A;
        if1.start = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        n = 0;
        while (n < 200 && !(dut1.bit_idx == 2 && dut1.launch == 1'b1)) begin
            @(posedge clk);
            #1 n++;
        end
        check("rst_reached_launch", 32'(n < 200), 32'h1);
        check("rst_partial_resp", 32'(dut1.response_q), 32'h3);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy",     32'(if1.busy), 32'h0);
        check("rst_launch",   32'(dut1.launch), 32'h0);
        check("rst_response", 32'(if1.response), 32'h0);
        check("rst_valid",    32'(if1.resp_valid), 32'h0);
        @(negedge clk) rst = 1'b0;
        run_req(8'hA5, 12'hFFF, lat, ok);
        check("rst_rerun_latency",  32'(lat), 32'(LAT));
        check("rst_rerun_response", 32'(if1.response), 32'hF);
        handshake1();

        // start while busy is ignored; busy rises one edge after acceptance.
        cur_votes = 12'h000;
        @(negedge clk);
        if1.challenge = 8'h3C;
        if1.start = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        check("busy_not_yet", 32'(if1.busy), 32'h0);
        @(posedge clk);
        #1 check("busy_rise", 32'(if1.busy), 32'h1);
        @(negedge clk);
        if1.challenge = 8'hFF;
        if1.start = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        check("busy_chal_q", 32'(dut1.chal_q), 32'h3C);
        lat = 2;
        while (lat < 300 && !if1.resp_valid) begin
            @(posedge clk);
            #1 lat++;
        end
        check("busy_latency", 32'(lat), 32'(LAT));
        handshake1();
        repeat (3) @(posedge clk);
        #1 check("busy_not_queued", 32'(if1.busy), 32'h0);

        // RESP_W > STAGES: rotation wraps back at bit 8.
        @(negedge clk);
        if2.challenge = 8'h01;
        if2.start = 1'b1;
        @(posedge clk);
        #1 if2.start = 1'b0;
        n = 0;
        while (n < 400 && dut2.bit_idx != 7) begin
            @(posedge clk);
            #1 n++;
        end
        check("wrap_bit7_chain", 32'(dut2.chain_chal), 32'h80);
        while (n < 400 && dut2.bit_idx != 8) begin
            @(posedge clk);
            #1 n++;
        end
        check("wrap_bit8_chain", 32'(dut2.chain_chal), 32'h01);
        while (n < 400 && !if2.resp_valid) begin
            @(posedge clk);
            #1 n++;
        end
        check("wrap_valid", 32'(if2.resp_valid), 32'h1);
        @(negedge clk) if2.resp_ready = 1'b1;
        @(posedge clk);
        #1 if2.resp_ready = 1'b0;
        check("wrap_valid_drop", 32'(if2.resp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbiter_puf_engine.md
# arbiter_puf_engine

Parametrised arbiter-PUF evaluation engine that generates a multi-bit response from one challenge word. It builds a STAGES-long crossed-MUX delay chain with an arbiter latch, and uses a controller FSM to sequence precharge, launch and sample. Each response bit is evaluated VOTES times and majority-voted. The engine sits between the PUF fabric and the AES key path, delivering a RESP_W-bit response and a per-bit stability mask over a valid/ready handshake.

## Interface
- STAGES, 64: delay-chain length and challenge width (≥ 2).
- RESP_W, 32: response bits per request (≥ 1).
- VOTES, 5: evaluations per bit; odd, 1..15.
- SETTLE_CYC, 4: cycles held in each of PRECHARGE and LAUNCH (≥ 1).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- challenge  in  STAGES  challenge word; latched on accepted start.
- busy  out  1  high from the cycle after acceptance until the response is delivered.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- response  out  RESP_W  majority-voted response, bit i from evaluation i.
- unstable  out  RESP_W  bit i set when its votes were not unanimous.

## Operation
- States: IDLE, PRECHARGE, LAUNCH, SAMPLE, DONE.
- IDLE:
  - start=1 latches challenge into chal_q and clears bit_idx, vote_cnt, ones_cnt, response and unstable.
  - Then goes to PRECHARGE.
- PRECHARGE:
  - launch=0 drives both chain inputs low; arbiter latch clear asserted.
  - Lasts SETTLE_CYC cycles, then LAUNCH.
- LAUNCH:
  - launch=1 on both chain inputs; arbiter clear deasserted.
  - Lasts SETTLE_CYC cycles, then SAMPLE.
- SAMPLE (one cycle):
  - ones_next = ones_cnt + arb_out.
  - If vote_cnt < VOTES-1: store ones_next, increment vote_cnt, go to PRECHARGE.
  - Otherwise commit the bit: response[bit_idx] = (ones_next > VOTES/2); unstable[bit_idx] = (ones_next ≠ 0 and ones_next ≠ VOTES).
  - After commit, clear vote_cnt and ones_cnt.
  - Then go to PRECHARGE with bit_idx+1, or to DONE if bit_idx = RESP_W-1.
- Per-bit challenge: rotl(chal_q, bit_idx mod STAGES). With RESP_W > STAGES, rotations wrap and repeat.
- Chain challenge is held constant through PRECHARGE/LAUNCH/SAMPLE of one evaluation. It changes only at the SAMPLE→PRECHARGE commit edge.
- DONE:
  - resp_valid=1; response and unstable held stable.
  - resp_valid & resp_ready → IDLE, with resp_valid dropping next cycle. response and unstable keep their values until the next accepted start.
- start while busy or in DONE is ignored and not queued.
- arb_out = 1 when the top path wins, 0 when the bottom path wins.
- Counter widths:
  - vote_cnt and ones_cnt: $clog2(VOTES+1) bits.
  - bit_idx: $clog2(RESP_W+1) bits.
  - phase counter: $clog2(SETTLE_CYC+1) bits.
  - No counter wraps within a request.

## Timing
- Reset values: busy=0, resp_valid=0, response=0, unstable=0, launch=0, arbiter clear=1, state=IDLE.
- rst mid-operation (any state) aborts the request within the same edge:
  - launch drops and all counters clear.
  - No partial response is presented.
- Per evaluation: 2·SETTLE_CYC+1 cycles.
- Start acceptance (edge N) to resp_valid high: 1 + RESP_W·VOTES·(2·SETTLE_CYC+1) cycles. Defaults give 1441.
- busy rises at edge N+1 and falls on the edge where the DONE handshake completes.
- Back-to-back: start may be accepted in the first IDLE cycle after a handshake.
- arb_out is sampled only in SAMPLE, SETTLE_CYC cycles after launch rises, and the sampling flop is clk-domain. The arbiter latch is expected to resolve within SETTLE_CYC cycles.

## Structure
- Package puf_pkg:
  - state enum puf_state_t.
  - function rotl(word, amount).
  - VOTES/SETTLE_CYC legality checks as elaboration-time functions.
- Sub-module puf_delay_chain (STAGES parameter):
  - generate loop of crossed MUX switch stages, challenge bit k selecting straight/crossed at stage k.
  - SR arbiter latch with clear.
  - Ports: launch, challenge, arb_clr, arb_out.
  - Carries the dont_touch attribute.
- Controller, counters and output registers live in arbiter_puf_engine.
- Bench binds a behavioural puf_delay_chain that returns scripted arb_out per evaluation.

## Test plan
- Reset then idle, STAGES=8, RESP_W=4, VOTES=3, SETTLE_CYC=2 → all outputs 0. start with challenge=0xA5 and all evaluations returning 1 → resp_valid after 1+4·3·5=61 cycles, response=0xF, unstable=0.
- Scripted votes for bit0=1,1,0, bit1=0,0,0, bit2=0,1,0, bit3=1,1,1 → response=0x9, unstable=0x5.
- Challenge check: challenge=0x01 → chain sees 0x01, 0x02, 0x04, 0x08 for bits 0..3. RESP_W=10, STAGES=8 → bit 8 sees 0x01 again.
- Hold resp_ready=0 for 20 cycles in DONE with start pulses → outputs stable, no restart. resp_ready=1 → IDLE next cycle.
- rst asserted during LAUNCH of bit 2 → next cycle busy=0, launch=0, response=0. A new start then runs a full 61-cycle request.
- start pulsed during busy → ignored, and latched challenge unchanged.
